// File: rtl/xm23_dev_pkg.sv
// Shared constants for the XM23 device controller: CSR bit positions, IO direction codes.
// csr_pack builds the CSR read byte so every user agrees on the bit layout.
package xm23_dev_pkg;

    localparam int CSR_IE  = 0;
    localparam int CSR_IO  = 1;
    localparam int CSR_DBA = 2;
    localparam int CSR_OF  = 3;
    localparam int CSR_ENA = 4;

    localparam logic IO_IN  = 1'b0;
    localparam logic IO_OUT = 1'b1;

    localparam int NUM_DEV_MAX = 8;

    function automatic logic [7:0] csr_pack(input logic ie, input logic io, input logic dba,
                                            input logic of, input logic ena);
        logic [7:0] v;
        v          = 8'h00;
        v[CSR_IE]  = ie;
        v[CSR_IO]  = io;
        v[CSR_DBA] = dba;
        v[CSR_OF]  = of;
        v[CSR_ENA] = ena;
        return v;
    endfunction

endpackage

// File: rtl/xm23_dev_ctrl_fifo.sv
// Per-channel byte FIFO. Push on full is accepted only when a pop happens in the same cycle;
// pop on empty is ignored, so an empty FIFO never bypasses din to dout.
module dev_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [CW-1:0]    r_cnt;
    logic             w_push, w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_dout  = r_mem[r_rp];
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage needs no reset: empty state masks whatever it holds.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wp] <= i_din;
    end

endmodule

// File: rtl/xm23_dev_ctrl.sv
// Memory-mapped XM23 device controller: NUM_DEV CSR/DATA byte pairs, each backed by a FIFO,
// with valid/ready device handshakes and a lowest-index-first interrupt request.
module xm23_dev_ctrl
    import xm23_dev_pkg::*;
#(
    parameter int          NUM_DEV    = 3,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] BASE       = 16'h0000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [15:0]          i_cpu_addr,
    input  logic [15:0]          i_cpu_wdata,
    input  logic                 i_cpu_wr,
    input  logic                 i_cpu_rd,
    input  logic                 i_cpu_wb,
    output logic [15:0]          o_cpu_rdata,
    output logic                 o_cpu_hit,
    input  logic [8*NUM_DEV-1:0] i_dev_rx_data,
    input  logic [NUM_DEV-1:0]   i_dev_rx_valid,
    output logic [NUM_DEV-1:0]   o_dev_rx_ready,
    output logic [8*NUM_DEV-1:0] o_dev_tx_data,
    output logic [NUM_DEV-1:0]   o_dev_tx_valid,
    input  logic [NUM_DEV-1:0]   i_dev_tx_ready,
    output logic                 o_irq_req,
    output logic [2:0]           o_irq_dev,
    input  logic                 i_irq_ack
);

    logic [16:0] w_off;
    logic        w_acc_csr, w_acc_data;
    logic [2:0]  w_ch;
    logic [7:0]  w_csr_wbyte, w_dat_wbyte;

    // 17-bit subtract: bit 16 flags an address below BASE.
    assign w_off       = {1'b0, i_cpu_addr} - {1'b0, BASE};
    assign o_cpu_hit   = ~w_off[16] & (w_off[15:0] < 16'(2 * NUM_DEV));
    assign w_ch        = w_off[3:1];
    assign w_acc_csr   = o_cpu_hit & (~i_cpu_wb | ~w_off[0]);
    assign w_acc_data  = o_cpu_hit & (~i_cpu_wb | w_off[0]);
    assign w_csr_wbyte = i_cpu_wdata[7:0];
    assign w_dat_wbyte = i_cpu_wb ? i_cpu_wdata[7:0] : i_cpu_wdata[15:8];

    logic [NUM_DEV-1:0] r_ie, r_io, r_ena, r_of, r_dba_q, r_pend;
    logic [NUM_DEV-1:0] w_csr_wr, w_dat_wr, w_dat_rd, w_io_chg, w_push, w_pop;
    logic [NUM_DEV-1:0] w_full, w_empty, w_dba, w_of_set, w_pend_set, w_ack;
    logic [NUM_DEV-1:0][7:0] w_head, w_csr_rval, w_dat_rval;
    logic [2:0]  w_irq_dev;
    logic [15:0] w_rdata;

    for (genvar k = 0; k < NUM_DEV; k++) begin : g_ch
        logic [7:0] w_rx_byte;
        assign w_rx_byte   = i_dev_rx_data[8*k +: 8];
        assign w_csr_wr[k] = i_cpu_wr & w_acc_csr  & (w_ch == 3'(k));
        assign w_dat_wr[k] = i_cpu_wr & w_acc_data & (w_ch == 3'(k));
        assign w_dat_rd[k] = i_cpu_rd & w_acc_data & (w_ch == 3'(k));
        assign w_io_chg[k] = w_csr_wr[k] & (w_csr_wbyte[CSR_IO] != r_io[k]);

        assign o_dev_rx_ready[k]   = (r_io[k] == IO_IN) & r_ena[k];
        assign o_dev_tx_valid[k]   = (r_io[k] == IO_OUT) & r_ena[k] & ~w_empty[k];
        assign o_dev_tx_data[8*k +: 8] = o_dev_tx_valid[k] ? w_head[k] : 8'h00;

        assign w_push[k] = (r_io[k] == IO_OUT) ? w_dat_wr[k] : (i_dev_rx_valid[k] & r_ena[k]);
        assign w_pop[k]  = (r_io[k] == IO_OUT) ? (o_dev_tx_valid[k] & i_dev_tx_ready[k]) : w_dat_rd[k];
        assign w_of_set[k]   = w_push[k] & w_full[k] & ~w_pop[k];
        assign w_dba[k]      = (r_io[k] == IO_OUT) ? ~w_full[k] : ~w_empty[k];
        assign w_pend_set[k] = r_ie[k] & w_dba[k] & ~r_dba_q[k];
        assign w_ack[k]      = i_irq_ack & (w_irq_dev == 3'(k));

        assign w_csr_rval[k] = csr_pack(r_ie[k], r_io[k], w_dba[k], r_of[k], r_ena[k]);
        assign w_dat_rval[k] = ((r_io[k] == IO_IN) && !w_empty[k]) ? w_head[k] : 8'h00;

        dev_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_push  (w_push[k]),
            .i_pop   (w_pop[k]),
            .i_flush (w_io_chg[k]),
            .i_din   ((r_io[k] == IO_OUT) ? w_dat_wbyte : w_rx_byte),
            .o_dout  (w_head[k]),
            .o_full  (w_full[k]),
            .o_empty (w_empty[k])
        );
    end

    always_comb begin
        w_irq_dev = 3'd0;
        for (int k = NUM_DEV - 1; k >= 0; k--) begin
            if (r_pend[k]) w_irq_dev = 3'(k);
        end
    end

    always_comb begin
        w_rdata = 16'h0000;
        for (int k = 0; k < NUM_DEV; k++) begin
            if (o_cpu_hit && w_ch == 3'(k)) begin
                if (!i_cpu_wb)     w_rdata = {w_dat_rval[k], w_csr_rval[k]};
                else if (w_off[0]) w_rdata = {8'h00, w_dat_rval[k]};
                else               w_rdata = {8'h00, w_csr_rval[k]};
            end
        end
    end

    assign o_cpu_rdata = w_rdata;
    assign o_irq_req   = |r_pend;
    assign o_irq_dev   = w_irq_dev;

    // A direction change wipes the channel; otherwise new overflow beats a CSR-write clear,
    // and a new pending set beats an ack on the same channel.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ie    <= '0;
            r_io    <= '0;
            r_ena   <= '0;
            r_of    <= '0;
            r_dba_q <= '0;
            r_pend  <= '0;
        end else begin
            r_dba_q <= w_dba;
            for (int k = 0; k < NUM_DEV; k++) begin
                if (w_csr_wr[k]) begin
                    r_ie[k]  <= w_csr_wbyte[CSR_IE];
                    r_io[k]  <= w_csr_wbyte[CSR_IO];
                    r_ena[k] <= w_csr_wbyte[CSR_ENA];
                end
                if (w_io_chg[k])      r_of[k] <= 1'b0;
                else if (w_of_set[k]) r_of[k] <= 1'b1;
                else if (w_csr_wr[k]) r_of[k] <= 1'b0;

                if (w_io_chg[k])        r_pend[k] <= 1'b0;
                else if (w_pend_set[k]) r_pend[k] <= 1'b1;
                else if (w_ack[k])      r_pend[k] <= 1'b0;
            end
        end
    end

endmodule
